// File: rtl/verifier_pkg.sv
// verifier_pkg: shared field width, layer-controller state and round-class types
package verifier_pkg;
  localparam int F_NBITS = 16;
  typedef enum logic [2:0] {IDLE, KICK, WAIT, WPREDS, ERR} vl_state_t;
  typedef enum logic [1:0] {COPY, W1, W2, FINAL} rnd_cls_t;
endpackage

// File: rtl/verifier_tau_sel.sv
// verifier_tau_sel: decodes the round class of a round index and muxes its challenge
module verifier_tau_sel import verifier_pkg::*; #(
  parameter int nCopyBits = 3,
  parameter int nInBits = 3,
  parameter int nRounds = nCopyBits + 2 * nInBits,
  parameter int nCountBits = $clog2(nRounds + 1)
) (
  input  logic [nCountBits-1:0]             count_i,
  input  logic [nCopyBits-1:0][F_NBITS-1:0] w3_vals_i,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w1_vals_i,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w2_vals_i,
  input  logic [F_NBITS-1:0]                tau_final_i,
  output rnd_cls_t                          cls_o,
  output logic [F_NBITS-1:0]                tau_o
);
  int c;
  always_comb begin
    c = int'(count_i);
    cls_o = c < nCopyBits ? COPY : c < nCopyBits + nInBits ? W1 : c < nRounds ? W2 : FINAL;
    tau_o = tau_final_i;
    for (int i = 0; i < nCopyBits; i++)
      if (c == i) tau_o = w3_vals_i[i];
    for (int i = 0; i < nInBits; i++) begin
      if (c == nCopyBits + i) tau_o = w1_vals_i[i];
      if (c == nCopyBits + nInBits + i) tau_o = w2_vals_i[i];
    end
  end
endmodule

// File: rtl/verifier_layer_ctl.sv
// verifier_layer_ctl: sequences copy/w1/w2 sum-check rounds with Horner and wiring-predicate handshakes
module verifier_layer_ctl import verifier_pkg::*; #(
  parameter int nCopyBits = 3,
  parameter int nInBits = 3,
  parameter int earlyAbort = 1,
  parameter int timeoutCycles = 255,
  parameter int nRounds = nCopyBits + 2 * nInBits,
  parameter int nCountBits = $clog2(nRounds + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              restart,
  input  logic [nCopyBits-1:0][F_NBITS-1:0] w3_vals,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w1_vals,
  input  logic [nInBits-1:0][F_NBITS-1:0]   w2_vals,
  input  logic [F_NBITS-1:0]                tau_final,
  output logic [F_NBITS-1:0]                tau_out,
  output logic [nCountBits-1:0]             round_idx,
  output logic                              horner_en,
  output logic                              horner_restart,
  output logic                              horner_cubic,
  output logic                              horner_round,
  input  logic                              horner_ready,
  input  logic                              horner_ok,
  input  logic [F_NBITS-1:0]                horner_val,
  output logic                              pred_en,
  output logic                              v1_v2_ready,
  input  logic                              pred_ready,
  input  logic [F_NBITS-1:0]                pred_val,
  output logic                              ok,
  output logic                              ready,
  output logic                              fin_layer,
  output logic                              timeout
);
  localparam int WB = $clog2(timeoutCycles + 1);
  localparam logic [WB-1:0] WD_LIM = WB'(timeoutCycles - 1);
  localparam logic [nCountBits-1:0] LAST_RND = nCountBits'(nRounds);
  vl_state_t state_q, state_d;
  logic [nCountBits-1:0] count_q, count_d;
  logic [WB-1:0] wait_cnt_q, wait_cnt_d;
  logic layok_q, layok_d, timeout_q, timeout_d, en_dly_q;
  logic start, wd_hit, waiting;
  rnd_cls_t cls;
  assign start = en & ~en_dly_q;
  assign waiting = state_q inside {WAIT, WPREDS};
  assign wd_hit = waiting && wait_cnt_q == WD_LIM;
  verifier_tau_sel #(.nCopyBits(nCopyBits), .nInBits(nInBits)) u_tau (
    .count_i(count_q), .w3_vals_i(w3_vals), .w1_vals_i(w1_vals), .w2_vals_i(w2_vals),
    .tau_final_i(tau_final), .cls_o(cls), .tau_o(tau_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wait_cnt_q <= '0;
      layok_q <= 1'b0;
      timeout_q <= 1'b0;
      en_dly_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_cnt_q <= wait_cnt_d;
      layok_q <= layok_d;
      timeout_q <= timeout_d;
      en_dly_q <= en;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    layok_d = layok_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (start && (restart || count_q < LAST_RND)) begin
        state_d = KICK;
        count_d = restart ? '0 : count_q + nCountBits'(1);
        layok_d = restart | layok_q;
      end
      KICK: state_d = WAIT;
      WAIT: if (horner_ready) begin
        if (earlyAbort != 0 && !horner_ok) begin
          layok_d = 1'b0;
          count_d = LAST_RND;
          state_d = IDLE;
        end else state_d = count_q < LAST_RND ? IDLE : WPREDS;
      end else if (wd_hit) begin
        timeout_d = 1'b1;
        state_d = ERR;
      end
      WPREDS: if (pred_ready) begin
        layok_d = layok_q & (pred_val == horner_val);
        state_d = IDLE;
      end else if (wd_hit) begin
        timeout_d = 1'b1;
        state_d = ERR;
      end
      ERR: if (start && restart) begin
        state_d = KICK;
        count_d = '0;
        layok_d = 1'b1;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    wait_cnt_d = (state_d inside {WAIT, WPREDS}) && state_d != state_q ? '0 :
                 waiting ? wait_cnt_q + WB'(1) : wait_cnt_q;
  end
  always_comb begin
    round_idx = count_q;
    horner_en = state_q == KICK;
    pred_en = state_q == KICK && count_q == '0;
    v1_v2_ready = state_q == WPREDS;
    horner_restart = count_q == '0;
    horner_cubic = cls == COPY;
    horner_round = cls != FINAL;
    timeout = timeout_q;
    ok = layok_q & horner_ok & ~timeout_q;
    ready = state_q == IDLE && !start;
    fin_layer = ready && count_q == LAST_RND;
  end
endmodule

// File: tb/tb_verifier_layer_ctl.sv
// tb_verifier_layer_ctl: scoreboard bench with a round-level reference model of the layer controller
module tb_verifier_layer_ctl;
  import verifier_pkg::*;
  localparam int NC = 2, NI = 2, NR = NC + 2 * NI, TO = 4;
  typedef struct {int r; int tau;} lexp_t;
  typedef struct {bit to; int r; bit fin; bit ok; bit wp; int lat;} dexp_t;
  logic clk = 0, rst, en, restart, horner_ready, horner_ok, pred_ready;
  logic [NC-1:0][F_NBITS-1:0] w3_vals;
  logic [NI-1:0][F_NBITS-1:0] w1_vals, w2_vals;
  logic [F_NBITS-1:0] tau_final, tau_out, horner_val, pred_val;
  logic [2:0] round_idx;
  logic horner_en, horner_restart, horner_cubic, horner_round, pred_en, v1_v2_ready;
  logic ok, ready, fin_layer, timeout;
  int total = 0, bad = 0, n_launch = 0;
  int taus[NR+1];
  int m_r = 0;
  bit m_layok = 0, m_err = 0;
  lexp_t launch_q[$];
  dexp_t done_q[$];
  verifier_layer_ctl #(.nCopyBits(NC), .nInBits(NI), .earlyAbort(1), .timeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .w3_vals(w3_vals), .w1_vals(w1_vals),
    .w2_vals(w2_vals), .tau_final(tau_final), .tau_out(tau_out), .round_idx(round_idx),
    .horner_en(horner_en), .horner_restart(horner_restart), .horner_cubic(horner_cubic),
    .horner_round(horner_round), .horner_ready(horner_ready), .horner_ok(horner_ok),
    .horner_val(horner_val), .pred_en(pred_en), .v1_v2_ready(v1_v2_ready),
    .pred_ready(pred_ready), .pred_val(pred_val), .ok(ok), .ready(ready),
    .fin_layer(fin_layer), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_fin"}, fin_layer, 0);
    check({tag, "_ok"}, ok, 0);
    check({tag, "_horner_en"}, horner_en, 0);
    check({tag, "_pred_en"}, pred_en, 0);
    check({tag, "_v1v2"}, v1_v2_ready, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_round"}, round_idx, 0);
  endtask
  // One start request; the model decides acceptance and what the round should report.
  task automatic do_round(input bit rs, input int hd, input bit hok, input int pd,
                          input int hv, input int pv, input bit hang, input bit rst_wp);
    bit acc, fin_rd;
    acc = m_err ? rs : (rs || m_r < NR);
    fin_rd = 0;
    if (acc) begin
      if (rs) begin m_r = 0; m_layok = 1; m_err = 0; end
      else m_r++;
      launch_q.push_back('{m_r, taus[m_r]});
      if (hang) begin
        m_err = 1;
        done_q.push_back('{1, m_r, 0, 0, 0, TO + 1});
      end else begin
        fin_rd = hok && m_r == NR;
        if (!hok) begin m_layok = 0; m_r = NR; end
        if (fin_rd && pv != hv) m_layok = 0;
        if (!rst_wp)
          done_q.push_back('{0, m_r, m_r == NR, m_layok && hok, fin_rd, fin_rd ? 3 + hd + pd : 2 + hd});
      end
    end
    horner_ok = hok;
    horner_val = F_NBITS'(hv);
    pred_val = F_NBITS'(pv);
    en = 1; restart = rs;
    tick;
    en = 0; restart = 0;
    if (acc) begin
      tick;
      if (hang) repeat (8) tick;
      else begin
        repeat (hd) tick;
        horner_ready = 1;
        tick;
        horner_ready = 0;
        if (fin_rd && rst_wp) begin
          rst = 1;
          tick;
          rst = 0;
          m_r = 0; m_layok = 0; m_err = 0;
          check_reset_outs("rst_wpreds");
        end else if (fin_rd) begin
          repeat (pd) tick;
          pred_ready = 1;
          tick;
          pred_ready = 0;
        end
      end
    end
    repeat (2) tick;
  endtask
  task automatic good_round(input bit rs);
    int h;
    h = int'($urandom_range(0, 65535));
    do_round(rs, int'($urandom_range(0, TO - 1)), 1, int'($urandom_range(0, TO - 1)), h, h, 0, 0);
  endtask
  initial begin : monitor
    lexp_t l;
    dexp_t d;
    bit busy = 0, saw_wp = 0, to_prev = 0;
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        launch_q.delete();
        done_q.delete();
      end else begin
        if (busy) begin
          cyc++;
          if (v1_v2_ready) saw_wp = 1;
        end
        if (horner_en) begin
          n_launch++;
          busy = 1; cyc = 0; saw_wp = 0;
          if (launch_q.size() == 0) check("unexpected_launch", 1, 0);
          else begin
            l = launch_q.pop_front();
            check("launch_round", round_idx, l.r);
            check("launch_tau", tau_out, l.tau);
            check("launch_cubic", horner_cubic, l.r < NC);
            check("launch_hrestart", horner_restart, l.r == 0);
            check("launch_hround", horner_round, l.r < NR);
            check("launch_pred_en", pred_en, l.r == 0);
          end
        end else if (busy && (ready || (timeout && !to_prev))) begin
          busy = 0;
          if (done_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            d = done_q.pop_front();
            check("done_timeout", timeout, d.to);
            check("done_ready", ready, !d.to);
            check("done_latency", cyc, d.lat);
            check("done_fin", fin_layer, d.fin);
            if (!d.to) begin
              check("done_round", round_idx, d.r);
              check("done_ok", ok, d.ok);
              check("done_wpreds", saw_wp, d.wp);
            end
          end
        end else if (busy && cyc > 30) begin
          busy = 0;
          check("done_bound", cyc, 0);
        end
      end
      to_prev = timeout;
    end
  end
  initial begin
    int nl, h;
    rst = 1; en = 1; restart = 0; horner_ready = 0; horner_ok = 1; pred_ready = 0;
    horner_val = '0; pred_val = '0;
    for (int i = 0; i < NC; i++) w3_vals[i] = F_NBITS'($urandom);
    for (int i = 0; i < NI; i++) begin
      w1_vals[i] = F_NBITS'($urandom);
      w2_vals[i] = F_NBITS'($urandom);
    end
    tau_final = F_NBITS'($urandom);
    for (int i = 0; i < NC; i++) taus[i] = int'(w3_vals[i]);
    for (int i = 0; i < NI; i++) begin
      taus[NC + i] = int'(w1_vals[i]);
      taus[NC + NI + i] = int'(w2_vals[i]);
    end
    taus[NR] = int'(tau_final);
    repeat (3) tick;
    rst = 0;
    repeat (4) tick;
    check_reset_outs("reset");
    check("en_high_no_start", n_launch, 0);
    en = 0;
    tick;
    good_round(1);
    for (int i = 0; i < NR; i++) good_round(0);
    check("layer_fin", fin_layer, 1);
    check("layer_ok", ok, 1);
    nl = n_launch;
    good_round(0);
    check("sat_round", round_idx, NR);
    check("sat_ready", ready, 1);
    check("sat_no_launch", n_launch, nl);
    good_round(1);
    for (int i = 0; i < NR - 1; i++) good_round(0);
    do_round(0, 1, 1, 1, 7, 5, 0, 0);
    check("mismatch_ok", ok, 0);
    check("mismatch_fin", fin_layer, 1);
    good_round(1);
    good_round(0);
    do_round(0, 2, 0, 0, 3, 3, 0, 0);
    check("abort_round", round_idx, NR);
    do_round(1, 0, 1, 0, 0, 0, 1, 0);
    nl = n_launch;
    good_round(0);
    check("err_ignore_launch", n_launch, nl);
    check("err_timeout", timeout, 1);
    check("err_ready", ready, 0);
    good_round(1);
    check("recover_round", round_idx, 0);
    check("recover_timeout", timeout, 0);
    for (int i = 0; i < 50; i++) begin
      h = int'($urandom_range(0, 65535));
      do_round(m_r == NR ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0),
               int'($urandom_range(0, TO - 1)), $urandom_range(0, 7) != 0,
               int'($urandom_range(0, TO - 1)), h,
               $urandom_range(0, 3) == 0 ? h ^ 1 : h, 0, 0);
    end
    good_round(1);
    for (int i = 0; i < NR - 1; i++) good_round(0);
    do_round(0, 1, 1, 0, 9, 9, 0, 1);
    repeat (3) tick;
    check("queues_drained", launch_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/verifier_layer_ctl.md
# verifier_layer_ctl

Sequencer for one sum-check layer of the verifier, generalising the per-layer round controller. It steps through copy-bit, w1 and w2 rounds, selects the round challenge `tau`, and handshakes with an external Horner evaluator and wiring-predicate engine. Over the previous generation it adds:
- per-layer predicate launch;
- an optional early abort on Horner failure;
- a watchdog timeout with a sticky error state;
- saturation of the round counter.

It sits between the layer top and the `verifier_compute_horner` / `verifier_compute_wpreds` instances.

## Interface
Parameters:
- `nCopyBits`, 3: copy-variable rounds (cubic), ≥1.
- `nInBits`, 3: input-variable rounds per w1 and per w2 phase, ≥1.
- `earlyAbort`, 1: 1 means a failing Horner check ends the layer immediately.
- `timeoutCycles`, 255: maximum wait cycles per handshake, ≥2.
- `nRounds`, `nCopyBits+2*nInBits`: derived; do not override.
- `nCountBits`, `$clog2(nRounds+1)`: derived; do not override.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous and active-high.
- `en`  in  1  start request. Acts on its rising edge.
- `restart`  in  1  sampled with the start edge. 1 means begin a new layer at round 0.
- `w3_vals`  in  `F_NBITS`×nCopyBits  copy-round challenges.
- `w1_vals`, `w2_vals`  in  `F_NBITS`×nInBits  w1 and w2 round challenges.
- `tau_final`  in  `F_NBITS`  final-point challenge.
- `tau_out`  out  `F_NBITS`  challenge for the current round.
- `round_idx`  out  nCountBits  current value of `count_reg`.
- `horner_en`, `horner_restart`, `horner_cubic`, `horner_round`  out  1  Horner controls.
- `horner_ready`, `horner_ok`  in  1  Horner status.
- `horner_val`  in  `F_NBITS`  Horner final value.
- `pred_en`, `v1_v2_ready`  out  1  predicate-engine controls.
- `pred_ready`  in  1  predicate-engine status.
- `pred_val`  in  `F_NBITS`  predicate-engine final value.
- `ok`, `ready`, `fin_layer`, `timeout`  out  1  status.

## Operation
- Start detection:
  - `start = en & ~en_dly`.
  - `en_dly` resets to 1, so an `en` held high through reset does not start the block.
- States: IDLE, KICK, WAIT, WPREDS, ERR.
- IDLE, on `start`:
  - If `restart`: `count_reg` ← 0 and `layok` ← 1.
  - Else if `count_reg` < nRounds: `count_reg` increments.
  - Else (already at nRounds, no `restart`): the start is ignored and the state stays IDLE.
  - In both non-ignored cases the next state is KICK.
- KICK, one cycle:
  - `horner_en` = 1.
  - `pred_en` = 1 only when `count_reg` = 0.
  - Next state is WAIT.
- WAIT, on `horner_ready`:
  - If `earlyAbort` and `~horner_ok`: `layok` ← 0, `count_reg` ← nRounds, next state IDLE.
  - Else if `count_reg` < nRounds: next state IDLE.
  - Else: next state WPREDS.
- WPREDS:
  - `v1_v2_ready` = 1 throughout.
  - On `pred_ready`: if `pred_val != horner_val`, `layok` ← 0. Next state IDLE.
- Watchdog:
  - `wait_cnt` clears on entry to WAIT or WPREDS and increments each cycle in those states.
  - When it reaches `timeoutCycles - 1` without the awaited ready, `timeout` ← 1 and the next state is ERR.
- ERR:
  - Outputs are inert: `ready` = 0 and `fin_layer` = 0.
  - Leaves only on `start` with `restart`, which clears `timeout` and takes the same action as IDLE-restart.
  - Any other start edge is ignored.
- `en` edges in KICK, WAIT and WPREDS are lost. `en_dly` still tracks `en`.
- Horner controls, combinational from `count_reg`:
  - `horner_restart` = (`count_reg` == 0).
  - `horner_cubic` = `count_reg` < nCopyBits.
  - `horner_round` = `count_reg` < nRounds.
- `tau_out`, combinational from `count_reg`:
  - `count_reg` < nCopyBits: `w3_vals[c]`.
  - Next nInBits values: `w1_vals[c - nCopyBits]`.
  - Next nInBits values: `w2_vals[c - nCopyBits - nInBits]`.
  - `count_reg` = nRounds: `tau_final`.
  - No latches.
- Status outputs:
  - `ok` = `layok & horner_ok & ~timeout`.
  - `ready` = (state == IDLE) & `~start`.
  - `fin_layer` = `ready` & (`count_reg` == nRounds).

## Timing
- Reset values: state IDLE, `count_reg` 0, `layok` 0, `timeout` 0, `wait_cnt` 0. Resulting outputs: `ready` 1, `fin_layer` 0, `ok` 0, `horner_en` 0, `pred_en` 0, `v1_v2_ready` 0.
- Start edge in cycle t: KICK in t+1, WAIT from t+2.
- `horner_ready` is ignored in KICK. In WAIT it is sampled every cycle.
- With `horner_ready` seen in cycle u, `ready` rises in u+1.
- Minimum round latency from start edge to `ready` is 3 cycles.
- `rst` mid-operation returns every register to its reset value on the next edge. Handshakes already in flight are abandoned.
- Simultaneous `horner_ready` and watchdog expiry: the ready wins.

## Structure
- Package `verifier_pkg` holds:
  - the `vl_state_t` enum for the state machine;
  - the round-class enum {COPY, W1, W2, FINAL}.
- Sub-module `verifier_tau_sel`: the combinational round-class decode and `tau_out` mux, parametrised on nCopyBits and nInBits.

## Test plan
Unless stated otherwise, nCopyBits=2, nInBits=2 (so nRounds=6) and the Horner/predicate stubs answer 2 cycles after enable.
- Restart plus 6 further starts, all matching: `round_idx` runs 0..6, `horner_cubic` is 1 for rounds 0–1 only, `pred_en` pulses once, `fin_layer`=1, `ok`=1.
- Final round with `pred_val`=5, `horner_val`=7: `ok`=0 after WPREDS, and `fin_layer` still asserts.
- With `earlyAbort`=1, `horner_ok`=0 at round 2: `round_idx` jumps to 6, `fin_layer`=1, `ok`=0, and no WPREDS entry occurs.
- With `timeoutCycles`=4 and a stub that never answers: `timeout`=1 exactly 4 cycles after WAIT entry, with `ready`=0. A later start without `restart` is ignored; a start with `restart` recovers to `round_idx`=0.
- `en` held high through reset: no start occurs. Extra start at `round_idx`=6 without `restart`: state remains IDLE. `rst` in WPREDS: all outputs return to their reset values on the next cycle.
